// File: rtl/wb_port_arbiter.sv
// Register-file write-port scheduler for the dual-issue core: two writeback lanes plus one
// long-latency result source share two write ports, with WAW resolution and starvation stall.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        wb0_en_i,
   input  logic [4:0]  wb0_rd_i,
   input  logic [31:0] wb0_data_i,
   input  logic        wb1_en_i,
   input  logic [4:0]  wb1_rd_i,
   input  logic [31:0] wb1_data_i,
   input  logic        lu_valid_i,
   input  logic [4:0]  lu_rd_i,
   input  logic [31:0] lu_data_i,
   output logic        lu_ready_o,
   output logic        we0_o,
   output logic [4:0]  waddr0_o,
   output logic [31:0] wdata0_o,
   output logic        we1_o,
   output logic [4:0]  waddr1_o,
   output logic [31:0] wdata1_o,
   output logic        stall_o
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {
      IDLE,
      FORCE
   } state_t;

   state_t      state;
   logic [3:0]  cnt;

   logic        r0, r1, rl;
   logic        lu_hit;
   logic        gnt0, gnt1;
   logic        xfer;

   logic        we0_nxt, we1_nxt;
   logic [4:0]  waddr0_nxt, waddr1_nxt;
   logic [31:0] wdata0_nxt, wdata1_nxt;

   // Request qualification: x0 writes are filtered, and on a lane WAW the younger lane 1 wins.
   assign r1 = wb1_en_i && (wb1_rd_i != 5'd0);
   assign r0 = wb0_en_i && (wb0_rd_i != 5'd0) && !(r1 && (wb0_rd_i == wb1_rd_i));
   assign rl = lu_valid_i && (lu_rd_i != 5'd0);

   // A long-latency result overwritten by a same-cycle lane write is stale; ack and drop it.
   assign lu_hit = rl && ((r0 && (lu_rd_i == wb0_rd_i)) || (r1 && (lu_rd_i == wb1_rd_i)));
   assign gnt0   = rl && !lu_hit && !r0;
   assign gnt1   = rl && !lu_hit && r0 && !r1;

   assign lu_ready_o = lu_valid_i && ((lu_rd_i == 5'd0) || lu_hit || gnt0 || gnt1);
   assign xfer       = lu_valid_i && lu_ready_o;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      we0_nxt    = 1'b0;
      waddr0_nxt = 5'd0;
      wdata0_nxt = 32'd0;
      we1_nxt    = 1'b0;
      waddr1_nxt = 5'd0;
      wdata1_nxt = 32'd0;

      if (r0) begin
         we0_nxt    = 1'b1;
         waddr0_nxt = wb0_rd_i;
         wdata0_nxt = wb0_data_i;
      end else if (gnt0) begin
         we0_nxt    = 1'b1;
         waddr0_nxt = lu_rd_i;
         wdata0_nxt = lu_data_i;
      end

      if (r1) begin
         we1_nxt    = 1'b1;
         waddr1_nxt = wb1_rd_i;
         wdata1_nxt = wb1_data_i;
      end else if (gnt1) begin
         we1_nxt    = 1'b1;
         waddr1_nxt = lu_rd_i;
         wdata1_nxt = lu_data_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         we0_o    <= 1'b0;
         waddr0_o <= 5'd0;
         wdata0_o <= 32'd0;
         we1_o    <= 1'b0;
         waddr1_o <= 5'd0;
         wdata1_o <= 32'd0;
      end else begin
         we0_o    <= we0_nxt;
         waddr0_o <= waddr0_nxt;
         wdata0_o <= wdata0_nxt;
         we1_o    <= we1_nxt;
         waddr1_o <= waddr1_nxt;
         wdata1_o <= wdata1_nxt;
      end
   end

   // Counts consecutive ungranted cycles of a pending long-latency result.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt <= 4'd0;
      end else if (xfer || !lu_valid_i) begin
         cnt <= 4'd0;
      end else if (cnt != LIMIT) begin
         cnt <= cnt + 4'd1;
      end
   end

   // Lanes keep priority while stalled; the frozen front end drains them so the port frees up.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= IDLE;
         stall_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((cnt == LIMIT) && !xfer) begin
                  state   <= FORCE;
                  stall_o <= 1'b1;
               end
            end
            FORCE: begin
               if (xfer) begin
                  state   <= IDLE;
                  stall_o <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               stall_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
